// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer block.
package alarm_pkg;

   localparam int unsigned HH_W   = 5;
   localparam int unsigned MM_W   = 6;
   localparam int unsigned SNZ_W  = 4;
   localparam int unsigned SCNT_W = 12;

   localparam int unsigned HH_MAX = 23;
   localparam int unsigned MM_MAX = 59;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_ALARM  = 2'd0;
   localparam logic [1:0] ADDR_CMD    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_SNOOZE = 2'd3;

   localparam int unsigned CMD_SNOOZE_BIT = 0;
   localparam int unsigned CMD_STOP_BIT   = 1;
   localparam int unsigned STAT_IRQ_BIT   = 3;

endpackage

// File: rtl/alarm_debounce.sv
// Two-flop synchronizer plus stability counter turning the raw switch into "armed".
module alarm_debounce
   import alarm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic armed
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Synchronize, then accept the new level only after it has been stable long enough.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         armed <= 1'b0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
         if (sync2 == armed) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            armed <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Avalon-MM alarm controller: register file, alarm match and RINGING/SNOOZE sequencing.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned RING_TIMEOUT_S  = 60,
   parameter int unsigned SNOOZE_DEFAULT  = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        sw_alarm,
   input  logic        tick_1s,
   input  logic [4:0]  cur_hh,
   input  logic [5:0]  cur_mm,
   input  logic [5:0]  cur_ss,
   output logic        buzzer,
   output logic        irq
);

   localparam int unsigned RW = $clog2(RING_TIMEOUT_S + 1);

   logic              armed;
   logic [HH_W-1:0]   alarm_hh;
   logic [MM_W-1:0]   alarm_mm;
   logic [SNZ_W-1:0]  snooze_min;
   state_t            state, state_nxt;
   logic [RW-1:0]     ring_cnt, ring_cnt_nxt;
   logic [SCNT_W-1:0] snooze_cnt, snooze_cnt_nxt;
   logic              irq_pend;

   logic              irq_set_c;
   logic              cmd_snooze_c;
   logic              cmd_stop_c;
   logic              match_c;
   logic              alarm_wr_ok_c;
   logic              unused_wd_c;

   alarm_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .sw_raw (sw_alarm),
      .armed  (armed)
   );

   assign cmd_snooze_c  = write && (address == ADDR_CMD) && writedata[CMD_SNOOZE_BIT];
   assign cmd_stop_c    = write && (address == ADDR_CMD) && writedata[CMD_STOP_BIT];
   assign match_c       = armed && tick_1s && (cur_ss == 6'd0)
                          && (cur_hh == alarm_hh) && (cur_mm == alarm_mm);
   assign alarm_wr_ok_c = (writedata[4:0] <= HH_W'(HH_MAX)) && (writedata[13:8] <= MM_W'(MM_MAX));
   assign unused_wd_c   = ^{writedata[31:14], writedata[7:5]};
   assign irq           = irq_pend;

   // Next-state logic; stop beats disarm beats snooze beats tick.
   always_comb begin
      state_nxt      = state;
      ring_cnt_nxt   = ring_cnt;
      snooze_cnt_nxt = snooze_cnt;
      irq_set_c      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (match_c) begin
               state_nxt    = ST_RINGING;
               ring_cnt_nxt = '0;
               irq_set_c    = 1'b1;
            end
         end
         ST_RINGING: begin
            if (cmd_stop_c || !armed) begin
               state_nxt = ST_IDLE;
            end else if (cmd_snooze_c) begin
               state_nxt      = ST_SNOOZE;
               snooze_cnt_nxt = SCNT_W'(snooze_min) * SCNT_W'(60);
            end else if (tick_1s) begin
               if (ring_cnt == RW'(RING_TIMEOUT_S - 1)) begin
                  state_nxt = ST_IDLE;
               end else begin
                  ring_cnt_nxt = ring_cnt + RW'(1);
               end
            end
         end
         ST_SNOOZE: begin
            if (cmd_stop_c || !armed) begin
               state_nxt = ST_IDLE;
            end else if (tick_1s) begin
               if (snooze_cnt == SCNT_W'(1)) begin
                  state_nxt    = ST_RINGING;
                  ring_cnt_nxt = '0;
                  irq_set_c    = 1'b1;
               end else begin
                  snooze_cnt_nxt = snooze_cnt - SCNT_W'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, counters and buzzer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ring_cnt   <= '0;
         snooze_cnt <= '0;
         buzzer     <= 1'b0;
      end else begin
         state      <= state_nxt;
         ring_cnt   <= ring_cnt_nxt;
         snooze_cnt <= snooze_cnt_nxt;
         buzzer     <= (state_nxt == ST_RINGING);
      end
   end

   // Software-visible registers; an interrupt set wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         alarm_hh   <= '0;
         alarm_mm   <= '0;
         snooze_min <= SNZ_W'(SNOOZE_DEFAULT);
         irq_pend   <= 1'b0;
      end else begin
         if (write && (address == ADDR_ALARM) && alarm_wr_ok_c) begin
            alarm_hh <= writedata[4:0];
            alarm_mm <= writedata[13:8];
         end
         if (write && (address == ADDR_SNOOZE) && (writedata[3:0] != 4'd0)) begin
            snooze_min <= writedata[3:0];
         end
         if (irq_set_c) begin
            irq_pend <= 1'b1;
         end else if (write && (address == ADDR_STATUS) && writedata[STAT_IRQ_BIT]) begin
            irq_pend <= 1'b0;
         end
      end
   end

   // Registered read mux, refreshed every cycle from address.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         case (address)
            ADDR_ALARM:  readdata <= {18'd0, alarm_mm, 3'd0, alarm_hh};
            ADDR_STATUS: readdata <= {28'd0, irq_pend, state, armed};
            ADDR_SNOOZE: readdata <= {28'd0, snooze_min};
            default:     readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with small debounce/ring parameters.
module tb_alarm_sequencer;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        sw_alarm;
   logic        tick_1s;
   logic [4:0]  cur_hh;
   logic [5:0]  cur_mm;
   logic [5:0]  cur_ss;
   logic        buzzer;
   logic        irq;

   int vectors = 0;
   int errors  = 0;

   alarm_sequencer #(
      .DEBOUNCE_CYCLES (4),
      .RING_TIMEOUT_S  (5),
      .SNOOZE_DEFAULT  (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .sw_alarm  (sw_alarm),
      .tick_1s   (tick_1s),
      .cur_hh    (cur_hh),
      .cur_mm    (cur_mm),
      .cur_ss    (cur_ss),
      .buzzer    (buzzer),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      step();
      write     = 1'b0;
      writedata = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      step();
      d = readdata;
   endtask

   task automatic tick();
      tick_1s = 1'b1;
      step();
      tick_1s = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      reset = 1'b1; address = 2'd0; write = 1'b0; writedata = '0;
      sw_alarm = 1'b0; tick_1s = 1'b0; cur_hh = '0; cur_mm = '0; cur_ss = 6'd1;
      step(); step();
      chk("reset_readdata", readdata, 32'h0);
      chk("reset_buzzer", {31'd0, buzzer}, 32'h0);
      chk("reset_irq", {31'd0, irq}, 32'h0);
      reset = 1'b0;
      rd(2'd2, d); chk("reset_status", d, 32'h0);
      rd(2'd3, d); chk("reset_snooze", d, 32'h1);
      rd(2'd0, d); chk("reset_alarm", d, 32'h0);

      // Two-cycle glitch must not arm
      sw_alarm = 1'b1; step(); step(); sw_alarm = 1'b0;
      repeat (6) step();
      rd(2'd2, d); chk("glitch_not_armed", d, 32'h0);

      // Stable edge: armed flips on the 6th edge, visible in readdata one edge later
      sw_alarm = 1'b1; address = 2'd2;
      repeat (6) step();
      chk("debounce_edge6_old", readdata, 32'h0);
      step();
      chk("debounce_edge7_armed", readdata, 32'h1);

      // Program 06:07 and hit it
      wr(2'd0, 32'h0000_0706);
      rd(2'd0, d); chk("alarm_readback", d, 32'h706);
      wr(2'd1, 32'h1);  // snooze in IDLE ignored
      rd(2'd2, d); chk("idle_cmd_ignored", d, 32'h1);
      cur_hh = 5'd6; cur_mm = 6'd7; cur_ss = 6'd0;
      tick();
      chk("ring_buzzer", {31'd0, buzzer}, 32'h1);
      chk("ring_irq", {31'd0, irq}, 32'h1);
      rd(2'd2, d); chk("ring_status", d, 32'hB);
      wr(2'd2, 32'h8);
      chk("irq_cleared", {31'd0, irq}, 32'h0);
      rd(2'd2, d); chk("ring_status_noirq", d, 32'h3);

      // Timeout after 5 ticks
      cur_ss = 6'd1;
      repeat (4) tick();
      chk("ring_after4", {31'd0, buzzer}, 32'h1);
      tick();
      chk("timeout_buzzer", {31'd0, buzzer}, 32'h0);
      rd(2'd2, d); chk("timeout_status", d, 32'h1);

      // Ring again, snooze for 60 ticks
      cur_ss = 6'd0;
      tick();
      chk("ring2_irq", {31'd0, irq}, 32'h1);
      wr(2'd2, 32'h8);
      cur_ss = 6'd1;
      wr(2'd1, 32'h1);
      rd(2'd2, d); chk("snooze_status", d, 32'h5);
      repeat (59) tick();
      rd(2'd2, d); chk("snooze_59", d, 32'h5);
      chk("snooze_59_buzzer", {31'd0, buzzer}, 32'h0);
      tick();
      chk("snooze_60_buzzer", {31'd0, buzzer}, 32'h1);
      chk("snooze_60_irq", {31'd0, irq}, 32'h1);
      rd(2'd2, d); chk("snooze_60_status", d, 32'hB);

      // Stop wins over snooze
      wr(2'd1, 32'h3);
      chk("stop_buzzer", {31'd0, buzzer}, 32'h0);
      rd(2'd2, d); chk("stop_status", d, 32'h9);
      rd(2'd1, d); chk("cmd_reads_zero", d, 32'h0);

      // Register boundaries
      wr(2'd0, 32'h0000_0718);
      rd(2'd0, d); chk("alarm_hh24_ignored", d, 32'h706);
      wr(2'd0, 32'h0000_3C06);
      rd(2'd0, d); chk("alarm_mm60_ignored", d, 32'h706);
      wr(2'd0, 32'h0000_3B17);
      rd(2'd0, d); chk("alarm_max_ok", d, 32'h3B17);
      wr(2'd3, 32'h0);
      rd(2'd3, d); chk("snooze_zero_ignored", d, 32'h1);
      wr(2'd3, 32'hF);
      rd(2'd3, d); chk("snooze_15", d, 32'hF);

      // Reset while ringing
      cur_hh = 5'd23; cur_mm = 6'd59; cur_ss = 6'd0;
      tick();
      chk("ring3_buzzer", {31'd0, buzzer}, 32'h1);
      reset = 1'b1;
      step();
      chk("rst_ring_buzzer", {31'd0, buzzer}, 32'h0);
      chk("rst_ring_irq", {31'd0, irq}, 32'h0);
      chk("rst_ring_readdata", readdata, 32'h0);
      reset = 1'b0;
      rd(2'd0, d); chk("rst_alarm_zero", d, 32'h0);

      // Re-arm, ring, then disarm via the switch
      repeat (8) step();
      wr(2'd0, 32'h0000_0706);
      cur_hh = 5'd6; cur_mm = 6'd7; cur_ss = 6'd0;
      tick();
      cur_ss = 6'd1;
      chk("ring4_buzzer", {31'd0, buzzer}, 32'h1);
      sw_alarm = 1'b0;
      repeat (8) step();
      chk("disarm_buzzer", {31'd0, buzzer}, 32'h0);
      rd(2'd2, d); chk("disarm_status", d, 32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
